// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI4-Stream frame generator with programmable length, count, gap and pattern
//
// Purpose: emits runs of AXI4-Stream frames for DMA S2MM stimulus or as an
// on-chip traffic source. Byte length, frame count, inter-frame gap and data
// pattern are sampled on start; a partial last beat is flagged through tkeep.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse; samples config and begins a run (only when idle)
//   abort             level; ends the run once the frame in flight completes
//   mode              0 counter, 1 running word, 2 LFSR, 3 counter
//   frame_bytes       bytes per frame
//   num_frames        frames per run
//   gap_cycles        idle cycles between frames
//   M_AXIS_*          master stream (tdata/tkeep/tlast/tvalid out, tready in)
//   busy              run in progress
//   done              one-cycle pulse at end of run
//   frame_cnt         frames completed in the current or last run
module axis_frame_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH = 4,
  parameter logic [27:0] FIXED_DATA = 28'h666A500,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned NFRM_WIDTH = 16,
  parameter int unsigned GAP_WIDTH  = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [LEN_WIDTH-1:0]    frame_bytes,
  input  logic [NFRM_WIDTH-1:0]   num_frames,
  input  logic [GAP_WIDTH-1:0]    gap_cycles,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tlast,
  output logic                    M_AXIS_tvalid,
  input  logic                    M_AXIS_tready,
  output logic                    busy,
  output logic                    done,
  output logic [NFRM_WIDTH-1:0]   frame_cnt
);

  localparam int unsigned BPB      = DATA_WIDTH / 8;
  localparam int unsigned LOG2_BPB = $clog2(BPB);
  localparam int unsigned LANES    = DATA_WIDTH / 32;
  localparam logic [DATA_WIDTH-CNTR_WIDTH-1:0] FIX = (DATA_WIDTH-CNTR_WIDTH)'(FIXED_DATA);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t                  state_q;
  logic [1:0]              mode_q;
  logic [LEN_WIDTH-1:0]    bytes_q;
  logic [NFRM_WIDTH-1:0]   nfrm_q;
  logic [GAP_WIDTH-1:0]    gap_q;
  logic [GAP_WIDTH-1:0]    gap_cnt_q;
  logic [LEN_WIDTH-1:0]    beat_q;
  logic [NFRM_WIDTH-1:0]   frame_cnt_q;
  logic [31:0]             run_q;
  logic [31:0]             lfsr_q;
  logic                    abort_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    tvalid_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [BPB-1:0]          tkeep_q;
  logic                    tlast_q;

  function automatic logic [LEN_WIDTH-1:0] beats_of(input logic [LEN_WIDTH-1:0] nbytes);
    logic [LEN_WIDTH:0] sum;
    // One extra bit so ceil() of the largest length cannot overflow.
    sum = {1'b0, nbytes} + (LEN_WIDTH+1)'(BPB - 1);
    return LEN_WIDTH'(sum >> LOG2_BPB);
  endfunction

  function automatic logic [BPB-1:0] last_keep(input logic [LEN_WIDTH-1:0] nbytes);
    logic [LOG2_BPB-1:0] rem;
    logic [BPB-1:0]      keep;
    rem = nbytes[LOG2_BPB-1:0];
    for (int i = 0; i < int'(BPB); i++) begin
      keep[i] = (rem == '0) || (i < int'(rem));
    end
    return keep;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]           m,
                                                    input logic [LEN_WIDTH-1:0] idx,
                                                    input logic [31:0]          run,
                                                    input logic [31:0]          lf);
    logic [DATA_WIDTH-1:0] d;
    case (m)
      2'd1:    d = {LANES{run}};
      2'd2:    d = {LANES{lf}};
      default: d = {FIX, CNTR_WIDTH'(idx)};
    endcase
    return d;
  endfunction

  logic                  hs;
  logic [31:0]           lfsr_nx;
  logic [1:0]            offer_mode;
  logic [LEN_WIDTH-1:0]  offer_bytes;
  logic [LEN_WIDTH-1:0]  offer_idx;
  logic [31:0]           offer_run;
  logic [31:0]           offer_lf;
  logic [DATA_WIDTH-1:0] offer_data;
  logic [BPB-1:0]        offer_keep;
  logic                  offer_last;

  assign hs      = tvalid_q & M_AXIS_tready;
  assign lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);

  // The beat to present next cycle if the FSM decides to offer one: first beat
  // of a run (from the live config), successor after a handshake, or first
  // beat after a gap.
  always_comb begin
    offer_mode  = mode_q;
    offer_bytes = bytes_q;
    offer_idx   = '0;
    offer_run   = run_q;
    offer_lf    = lfsr_q;
    if (state_q == IDLE) begin
      offer_mode  = mode;
      offer_bytes = frame_bytes;
      offer_lf    = LFSR_SEED;
    end else if (state_q == SEND) begin
      offer_run = run_q + 32'd1;
      offer_lf  = lfsr_nx;
      if (!tlast_q) offer_idx = beat_q + LEN_WIDTH'(1);
    end
    offer_data = pattern(offer_mode, offer_idx, offer_run, offer_lf);
    offer_last = (offer_idx == beats_of(offer_bytes) - LEN_WIDTH'(1));
    offer_keep = offer_last ? last_keep(offer_bytes) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      bytes_q     <= '0;
      nfrm_q      <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      run_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q      <= mode;
            bytes_q     <= frame_bytes;
            nfrm_q      <= num_frames;
            gap_q       <= gap_cycles;
            frame_cnt_q <= '0;
            abort_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            if (frame_bytes == '0 || num_frames == '0) begin
              state_q <= FIN;
            end else begin
              state_q  <= SEND;
              busy_q   <= 1'b1;
              tvalid_q <= 1'b1;
              beat_q   <= offer_idx;
              tdata_q  <= offer_data;
              tkeep_q  <= offer_keep;
              tlast_q  <= offer_last;
            end
          end
        end
        SEND: begin
          // Abort is remembered so a short pulse mid-frame still ends the run
          // at the frame boundary.
          if (abort) abort_q <= 1'b1;
          if (hs) begin
            run_q  <= offer_run;
            lfsr_q <= offer_lf;
            if (tlast_q && (frame_cnt_q + NFRM_WIDTH'(1) == nfrm_q || abort || abort_q)) begin
              frame_cnt_q <= frame_cnt_q + NFRM_WIDTH'(1);
              state_q     <= FIN;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
            end else if (tlast_q && gap_q != '0) begin
              frame_cnt_q <= frame_cnt_q + NFRM_WIDTH'(1);
              state_q     <= GAP;
              gap_cnt_q   <= gap_q;
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
            end else begin
              if (tlast_q) frame_cnt_q <= frame_cnt_q + NFRM_WIDTH'(1);
              beat_q  <= offer_idx;
              tdata_q <= offer_data;
              tkeep_q <= offer_keep;
              tlast_q <= offer_last;
            end
          end
        end
        GAP: begin
          if (abort || abort_q) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
            state_q  <= SEND;
            tvalid_q <= 1'b1;
            beat_q   <= offer_idx;
            tdata_q  <= offer_data;
            tkeep_q  <= offer_keep;
            tlast_q  <= offer_last;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
          end
        end
        FIN: begin
          // Runs that ended after traffic arrive here with done already high;
          // empty runs arrive with done low and pulse it on the way out.
          state_q <= IDLE;
          done_q  <= ~done_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tkeep  = tkeep_q;
  assign M_AXIS_tlast  = tlast_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - self-checking bench for axis_frame_gen
`timescale 1ns/1ps
module tb_axis_frame_gen;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, abort, tready;
  logic [1:0]  mode;
  logic [15:0] frame_bytes, num_frames;
  logic [7:0]  gap_cycles;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, busy, done;
  logic [15:0] frame_cnt;

  logic        start64, tready64;
  logic [63:0] tdata64;
  logic [7:0]  tkeep64;
  logic        tlast64, tvalid64, busy64, done64;
  logic [15:0] frame_cnt64;

  axis_frame_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .frame_bytes(frame_bytes), .num_frames(num_frames), .gap_cycles(gap_cycles),
    .M_AXIS_tdata(tdata), .M_AXIS_tkeep(tkeep), .M_AXIS_tlast(tlast),
    .M_AXIS_tvalid(tvalid), .M_AXIS_tready(tready),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  axis_frame_gen #(.DATA_WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(start64), .abort(abort), .mode(mode),
    .frame_bytes(frame_bytes), .num_frames(num_frames), .gap_cycles(gap_cycles),
    .M_AXIS_tdata(tdata64), .M_AXIS_tkeep(tkeep64), .M_AXIS_tlast(tlast64),
    .M_AXIS_tvalid(tvalid64), .M_AXIS_tready(tready64),
    .busy(busy64), .done(done64), .frame_cnt(frame_cnt64)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0] mode;
    int         bytes;
    int         nfrm;
    int         gap;
    bit         rnd;
    int         abort_at;
    bit         spur;
    int         exp_frames;
    int         lat;
  } row_t;

  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  beat_t sb[$];
  beat_t mon_e;
  int    run_m = 0;

  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [36:0] prev_beat;
  bit          in_gap = 1'b0;
  int          idle_cnt, cur_gap, acc_beats, last_hs_cyc, done_cyc, done_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Expected beats for a whole run, generated when the run is started.
  task automatic push_run(input row_t r);
    logic [31:0] lf;
    int nb, rem;
    beat_t e;
    lf  = SEED;
    nb  = (r.bytes + 3) / 4;
    rem = r.bytes % 4;
    for (int f = 0; f < r.exp_frames; f++) begin
      for (int b = 0; b < nb; b++) begin
        case (r.mode)
          2'd1:    e.data = 32'(run_m);
          2'd2:    e.data = lf;
          default: e.data = 32'h666A_5000 | 32'(b % 16);
        endcase
        e.last = (b == nb - 1);
        e.keep = (e.last && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
        sb.push_back(e);
        run_m++;
        lf = lfsr_step(lf);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (tvalid && prev_stall) chk("stall_hold", 96'({tdata, tkeep, tlast}), 96'(prev_beat));
      prev_stall = tvalid && !tready;
      prev_beat  = {tdata, tkeep, tlast};
      if (in_gap) begin
        if (tvalid) begin
          chk("gap_len", 96'(idle_cnt), 96'(cur_gap));
          in_gap = 1'b0;
        end else begin
          idle_cnt++;
        end
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_beat: got %0h expected no beat", tdata);
        end else begin
          mon_e = sb.pop_front();
          chk("beat", 96'({tdata, tkeep, tlast}), 96'({mon_e.data, mon_e.keep, mon_e.last}));
        end
        acc_beats++;
        if (tlast) begin
          last_hs_cyc = cyc;
          in_gap      = 1'b1;
          idle_cnt    = 0;
        end
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
        chk("busy_at_done", 96'(busy), 96'(0));
      end
    end
  end

  task automatic run_row(input row_t r);
    int  t0;
    bit  got;
    @(posedge clk); #1;
    in_gap = 1'b0; prev_stall = 1'b0; acc_beats = 0; done_cnt = 0; cur_gap = r.gap;
    mode = r.mode; frame_bytes = 16'(r.bytes); num_frames = 16'(r.nfrm); gap_cycles = 8'(r.gap);
    tready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    t0 = cyc;
    push_run(r);
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the config inputs; the run must use the sampled values.
    mode = 2'd1; frame_bytes = 16'hFFFF; num_frames = 16'd7; gap_cycles = 8'd0;
    tready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    chk("first_valid", 96'(tvalid), 96'(r.exp_frames != 0));
    chk("busy_start", 96'(busy), 96'(r.exp_frames != 0));
    chk("fcnt_start", 96'(frame_cnt), 96'(0));
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(posedge clk); #1;
      tready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r.abort_at >= 0 && acc_beats >= r.abort_at) abort = 1'b1;
      if (r.spur && k == 2) begin
        start = 1'b1; mode = 2'd1; frame_bytes = 16'd4; num_frames = 16'd9;
      end else begin
        start = 1'b0;
      end
      got = (done_cnt != 0);
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end else begin
      chk("done_width", 96'(done), 96'(0));
      chk("busy_end", 96'(busy), 96'(0));
      chk("frame_cnt", 96'(frame_cnt), 96'(r.exp_frames));
      chk("beat_total", 96'(acc_beats), 96'(((r.bytes + 3) / 4) * r.exp_frames));
      chk("sb_drained", 96'(sb.size()), 96'(0));
      if (r.exp_frames != 0) chk("done_lat", 96'(done_cyc - last_hs_cyc), 96'(r.lat));
      else                   chk("done_lat", 96'(done_cyc - t0), 96'(r.lat));
    end
    abort = 1'b0;
    start = 1'b0;
    sb.delete();
  endtask

  row_t        rows[12];
  row_t        rr;
  logic [72:0] cap64[4];
  int          n64, d64, vcnt;

  initial begin
    rows[0]  = '{2'd1, 40, 3, 5, 1'b1, -1, 1'b0, 3, 1};
    rows[1]  = '{2'd0, 64, 1, 0, 1'b0, -1, 1'b0, 1, 1};
    rows[2]  = '{2'd0, 13, 2, 0, 1'b1, -1, 1'b0, 2, 1};
    rows[3]  = '{2'd2, 20, 2, 2, 1'b0, -1, 1'b0, 2, 1};
    rows[4]  = '{2'd2, 20, 2, 2, 1'b1, -1, 1'b0, 2, 1};
    rows[5]  = '{2'd0, 32, 4, 1, 1'b0,  2, 1'b0, 1, 1};
    rows[6]  = '{2'd0,  8, 3, 6, 1'b0,  2, 1'b0, 1, 2};
    rows[7]  = '{2'd3,  7, 1, 0, 1'b0, -1, 1'b0, 1, 1};
    rows[8]  = '{2'd0, 80, 1, 0, 1'b1, -1, 1'b0, 1, 1};
    rows[9]  = '{2'd0,  8, 2, 3, 1'b0, -1, 1'b1, 2, 1};
    rows[10] = '{2'd0,  0, 2, 0, 1'b0, -1, 1'b0, 0, 2};
    rows[11] = '{2'd0, 16, 0, 0, 1'b0, -1, 1'b0, 0, 2};

    rst = 1'b1; start = 1'b0; abort = 1'b0; tready = 1'b0; start64 = 1'b0; tready64 = 1'b0;
    mode = 2'd0; frame_bytes = 16'd0; num_frames = 16'd0; gap_cycles = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 96'(tvalid), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_outs", 96'({tdata, tkeep, tlast, frame_cnt}), 96'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) run_row(rows[i]);

    // Reset in the middle of a frame.
    rr = '{2'd0, 64, 1, 0, 1'b0, -1, 1'b0, 1, 1};
    @(posedge clk); #1;
    in_gap = 1'b0; prev_stall = 1'b0; acc_beats = 0; done_cnt = 0;
    mode = 2'd0; frame_bytes = 16'd64; num_frames = 16'd1; gap_cycles = 8'd0; tready = 1'b1;
    start = 1'b1;
    push_run(rr);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && acc_beats < 5; k++) @(posedge clk);
    #1;
    chk("rst_setup_beats", 96'(acc_beats >= 5), 96'(1));
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", 96'(tvalid), 96'(0));
    chk("midrst_busy", 96'(busy), 96'(0));
    chk("midrst_fcnt", 96'(frame_cnt), 96'(0));
    vcnt = 0; d64 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tvalid) vcnt++;
      if (done) d64++;
    end
    chk("midrst_quiet", 96'({vcnt, d64}), 96'(0));
    sb.delete();
    run_m = 0;

    // 64-bit instance: 13 bytes -> two beats, 5 bytes valid in the last.
    @(posedge clk); #1;
    mode = 2'd0; frame_bytes = 16'd13; num_frames = 16'd1; gap_cycles = 8'd0;
    tready64 = 1'b1; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    n64 = 0; d64 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tvalid64 && tready64) begin
        if (n64 < 4) cap64[n64] = {tdata64, tkeep64, tlast64};
        n64++;
      end
      if (done64) d64++;
    end
    chk("w64_beats", 96'(n64), 96'(2));
    if (n64 >= 2) begin
      chk("w64_beat0", 96'(cap64[0]), 96'({64'h0000_0000_666A_5000, 8'hFF, 1'b0}));
      chk("w64_beat1", 96'(cap64[1]), 96'({64'h0000_0000_666A_5001, 8'h1F, 1'b1}));
    end
    chk("w64_done", 96'(d64), 96'(1));
    chk("w64_fcnt", 96'(frame_cnt64), 96'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
